// File: rtl/jtgng_sync_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : jtgng_sync_rx
// Purpose : Video timing receiver. Rebuilds active pixel/line coordinates from
//           LHBL/LVBL/HS/VS, measures frame geometry and reports lock.
//           Optional HS watchdog enabled by defining JTGNG_SYNCRX_WDOG_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module jtgng_sync_rx #(
  parameter int LOCK_FRAMES = 2,
  parameter int WDOG_TICKS  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen6,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic       HS,
  input  logic       VS,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] htotal,
  output logic [9:0] hactive,
  output logic [9:0] vtotal,
  output logic [9:0] vactive,
  output logic       locked,
  output logic       wdog
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_CHECK   = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam logic [2:0] c_need = 3'(LOCK_FRAMES - 1);

  function automatic logic [9:0] sat10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  logic r_lhbl, r_lhbl_l, r_lvbl, r_lvbl_l;
  logic r_hs, r_hs_l, r_vs, r_vs_l;
  logic w_hb_rise, w_hb_fall, w_vb_rise, w_hs_rise, w_vs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_lhbl, r_lhbl_l, r_lvbl, r_lvbl_l} <= '0;
      {r_hs, r_hs_l, r_vs, r_vs_l}         <= '0;
    end else if (cen6) begin
      r_lhbl   <= LHBL;
      r_lhbl_l <= r_lhbl;
      r_lvbl   <= LVBL;
      r_lvbl_l <= r_lvbl;
      r_hs     <= HS;
      r_hs_l   <= r_hs;
      r_vs     <= VS;
      r_vs_l   <= r_vs;
    end
  end

  assign w_hb_rise = r_lhbl & ~r_lhbl_l;
  assign w_hb_fall = ~r_lhbl & r_lhbl_l;
  assign w_vb_rise = r_lvbl & ~r_lvbl_l;
  assign w_hs_rise = r_hs & ~r_hs_l;
  assign w_vs_rise = r_vs & ~r_vs_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (cen6) begin
      line_start  <= w_hb_rise & r_lvbl;
      frame_start <= w_vs_rise;
      if (w_hb_rise)
        hcnt <= '0;
      else if (r_lhbl && hcnt != 9'h1ff)
        hcnt <= hcnt + 9'd1;
      if (w_vb_rise)
        vcnt <= '0;
      else if (w_hb_fall && r_lvbl && vcnt != 9'h1ff)
        vcnt <= vcnt + 9'd1;
    end
  end

  logic [9:0] r_htick, r_hact, r_hlen, r_halen;
  logic [9:0] r_lines, r_alines;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_htick  <= '0;
      r_hact   <= '0;
      r_hlen   <= '0;
      r_halen  <= '0;
      r_lines  <= '0;
      r_alines <= '0;
    end else if (cen6) begin
      if (w_hs_rise) begin
        r_hlen  <= r_htick;
        r_halen <= r_hact;
        r_htick <= 10'd1;
        r_hact  <= {9'd0, r_lhbl};
      end else begin
        r_htick <= sat10(r_htick);
        if (r_lhbl)
          r_hact <= sat10(r_hact);
      end
      // An HS/LHBL edge coincident with VS belongs to the new frame
      if (w_vs_rise) begin
        r_lines  <= {9'd0, w_hs_rise};
        r_alines <= {9'd0, w_hb_rise & r_lvbl};
      end else begin
        if (w_hs_rise)
          r_lines <= sat10(r_lines);
        if (w_hb_rise && r_lvbl)
          r_alines <= sat10(r_alines);
      end
    end
  end

  logic [9:0]  w_m_hlen, w_m_halen;
  logic [39:0] w_m;

  assign w_m_hlen  = w_hs_rise ? r_htick : r_hlen;
  assign w_m_halen = w_hs_rise ? r_hact  : r_halen;
  assign w_m       = {w_m_hlen, w_m_halen, r_lines, r_alines};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      htotal  <= '0;
      hactive <= '0;
      vtotal  <= '0;
      vactive <= '0;
    end else if (cen6 && w_vs_rise) begin
      htotal  <= w_m_hlen;
      hactive <= w_m_halen;
      vtotal  <= r_lines;
      vactive <= r_alines;
    end
  end

`ifdef JTGNG_SYNCRX_WDOG_EN
  localparam int WDW = $clog2(WDOG_TICKS + 1);
  localparam logic [WDW-1:0] c_wd_lim = WDW'(WDOG_TICKS);

  logic [WDW-1:0] r_wd;
  logic           r_wdog;
  logic           w_wd_fire;

  // Fires once as the counter reaches the limit, then holds until the next HS
  assign w_wd_fire = ~w_hs_rise & (r_wd == c_wd_lim - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd   <= '0;
      r_wdog <= 1'b0;
    end else if (cen6) begin
      r_wdog <= w_wd_fire;
      if (w_hs_rise)
        r_wd <= '0;
      else if (r_wd != c_wd_lim)
        r_wd <= r_wd + 1'b1;
    end
  end

  assign wdog = r_wdog;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_TICKS != 0);
  assign wdog          = 1'b0;
`endif

  state_t      r_state, w_state_nxt;
  logic [39:0] r_cand, w_cand_nxt;
  logic [2:0]  r_matches, w_matches_nxt;
  logic [2:0]  w_match_inc;

  assign w_match_inc = r_matches + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_SEARCH;
      r_cand    <= '0;
      r_matches <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_matches <= w_matches_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_matches_nxt = r_matches;
    if (cen6 && w_vs_rise) begin
      case (r_state)
        S_SEARCH:  w_state_nxt = S_MEASURE;
        S_MEASURE: begin
          w_state_nxt   = S_CHECK;
          w_cand_nxt    = w_m;
          w_matches_nxt = '0;
        end
        S_CHECK: begin
          if (w_m == r_cand) begin
            w_matches_nxt = w_match_inc;
            if (w_match_inc >= c_need)
              w_state_nxt = S_LOCKED;
          end else begin
            w_cand_nxt    = w_m;
            w_matches_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (w_m != r_cand) begin
            w_state_nxt   = S_CHECK;
            w_cand_nxt    = w_m;
            w_matches_nxt = '0;
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
`ifdef JTGNG_SYNCRX_WDOG_EN
    if (cen6 && w_wd_fire) begin
      w_state_nxt   = S_SEARCH;
      w_matches_nxt = '0;
    end
`endif
  end

  assign locked = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_jtgng_sync_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_jtgng_sync_rx
// Purpose : Scoreboard bench for jtgng_sync_rx on a scaled-down video raster.
//           Watchdog expectations follow JTGNG_SYNCRX_WDOG_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_jtgng_sync_rx;
  // Scaled raster: 48 ticks/line, 32 active, HS at 36; 20 lines, 14 active, VS at 16
  localparam int HT = 48, HA = 32, HS0 = 36, HSW = 4;
  localparam int VT = 20, VA = 14, VS0 = 16, VSW = 2;
  localparam int ALL = 1 << 30;

  logic       clk = 1'b0, rst_n = 1'b0, cen6 = 1'b0;
  logic       LHBL = 1'b0, LVBL = 1'b0, HS = 1'b0, VS = 1'b0;
  logic [8:0] hcnt, vcnt;
  logic       line_start, frame_start, locked, wdog;
  logic [9:0] htotal, hactive, vtotal, vactive;

  typedef struct {
    int htotal;
    int hactive;
    int vtotal;
    int vactive;
    int locked;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   nls = 0, nbad = 0, hmax = 0, wdog_seen = 0;

  jtgng_sync_rx #(.LOCK_FRAMES(2), .WDOG_TICKS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .cen6(cen6),
    .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
    .hcnt(hcnt), .vcnt(vcnt), .line_start(line_start), .frame_start(frame_start),
    .htotal(htotal), .hactive(hactive), .vtotal(vtotal), .vactive(vactive),
    .locked(locked), .wdog(wdog)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step(input logic lh, input logic lv, input logic hs, input logic vs);
    @(negedge clk);
    cen6 = 1'b1;
    LHBL = lh; LVBL = lv; HS = hs; VS = vs;
    @(negedge clk);
    cen6 = 1'b0;
  endtask

  task automatic frame(input int vt, input int vs_h, input int nticks);
    int h, v;
    for (int p = 0; p < vt * HT && p < nticks; p++) begin
      h = p % HT;
      v = p / HT;
      step(h < HA, v < VA, (h >= HS0) && (h < HS0 + HSW),
           (p >= VS0 * HT + vs_h) && (p < (VS0 + VSW) * HT + vs_h));
    end
  endtask

  task automatic expect_vs(input int vt, input int lk);
    exp_t e;
    e.htotal  = HT;
    e.hactive = HA;
    e.vtotal  = vt;
    e.vactive = VA;
    e.locked  = lk;
    sb.push_back(e);
  endtask

  initial begin : monitor
    logic c;
    exp_t e;
    forever begin
      @(posedge clk);
      c = cen6;
      #1;
      if (!rst_n) begin
        nls = 0; nbad = 0; hmax = 0;
      end else if (c) begin
        if (wdog) wdog_seen++;
        if (int'(hcnt) > hmax) hmax = int'(hcnt);
        if (line_start) begin
          if (hcnt != 9'd0 || int'(vcnt) != nls) nbad++;
          nls++;
        end
        if (frame_start) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("htotal",  int'(htotal),  e.htotal);
            check("hactive", int'(hactive), e.hactive);
            check("vtotal",  int'(vtotal),  e.vtotal);
            check("vactive", int'(vactive), e.vactive);
            check("locked",  int'(locked),  e.locked);
            check("line_starts", nls, VA);
            check("bad_line_coords", nbad, 0);
            check("hcnt_max", hmax, HA - 1);
          end
          nls = 0; nbad = 0; hmax = 0;
        end
      end
    end
  end

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_outputs_zero",
          int'(|{hcnt, vcnt, line_start, frame_start, htotal, hactive,
                 vtotal, vactive, locked, wdog}), 0);
    rst_n = 1'b1;

    expect_vs(16, 0); frame(VT, 0, ALL);        // partial first frame
    expect_vs(20, 0); frame(VT, 0, ALL);
    expect_vs(20, 1); frame(VT, 0, ALL);        // lock on third VS
    expect_vs(20, 1); frame(VT, 0, ALL);
    expect_vs(20, 1); frame(VT - 1, 0, ALL);    // short frame, seen at next VS
    expect_vs(19, 0); frame(VT, 0, ALL);
    expect_vs(20, 0); frame(VT, 0, ALL);
    expect_vs(20, 1); frame(VT, 0, ALL);        // relock
    expect_vs(20, 1); frame(VT, HS0, ALL);      // VS coincides with HS
    expect_vs(20, 1); frame(VT, 0, ALL);

    frame(VT, 0, 5 * HT + 10);                  // stop mid-line 5
    check("pre_reset_hcnt", int'(hcnt), 8);
    rst_n = 1'b0;
    #1;
    check("async_reset_zero",
          int'(|{hcnt, vcnt, line_start, frame_start, htotal, hactive,
                 vtotal, vactive, locked, wdog}), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    expect_vs(16, 0); frame(VT, 0, ALL);
    expect_vs(20, 0); frame(VT, 0, ALL);
    expect_vs(20, 1); frame(VT, 0, ALL);
    check("locked_after_reset", int'(locked), 1);

    repeat (1100) step(1'b0, 1'b0, 1'b0, 1'b0);  // HS stopped
`ifdef JTGNG_SYNCRX_WDOG_EN
    check("wdog_pulses", wdog_seen, 1);
    check("wdog_unlock", int'(locked), 0);
`else
    check("wdog_pulses", wdog_seen, 0);
    check("no_wdog_locked", int'(locked), 1);
`endif
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
